// File: rtl/panel_timing_gen.sv
// Frame timing generator for the TFT panel readout path: panel reset, integration and ROI row/column readout.
// Optional pixel decimation is enabled by defining TG_DECIMATE_EN.
module panel_timing_gen #(
   parameter int ADDR_W       = 12,
   parameter int INT_W        = 16,
   parameter int CLK_FREQ_MHZ = 100,
   parameter int RESET_US     = 10,
   parameter int ROW_DIV      = 20,
   parameter int COL_DIV      = 10,
   parameter int FCNT_W       = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              frame_start,
   input  logic              frame_abort,
   input  logic              continuous,
   input  logic [INT_W-1:0]  integration_ms,
   input  logic [ADDR_W-1:0] row_start,
   input  logic [ADDR_W-1:0] row_end,
   input  logic [ADDR_W-1:0] col_start,
   input  logic [ADDR_W-1:0] col_end,
   input  logic [1:0]        row_step,
   input  logic [1:0]        col_step,
   output logic              frame_busy,
   output logic              frame_complete,
   output logic              frame_aborted,
   output logic              cfg_error,
   output logic [FCNT_W-1:0] frame_count,
   output logic [ADDR_W-1:0] row_addr,
   output logic [ADDR_W-1:0] col_addr,
   output logic              row_clk_en,
   output logic              col_clk_en,
   output logic              adc_start_trigger,
   output logic              gate_sel,
   output logic              reset_pulse,
   output logic [2:0]        state_o
);

   localparam int RESET_CYCLES = CLK_FREQ_MHZ * RESET_US;
   localparam int CYC_PER_MS   = CLK_FREQ_MHZ * 1000;
   localparam int CNT_MAX_A    = (RESET_CYCLES > ROW_DIV) ? RESET_CYCLES : ROW_DIV;
   localparam int CNT_MAX      = (CNT_MAX_A > COL_DIV) ? CNT_MAX_A : COL_DIV;
   localparam int CNT_W        = $clog2(CNT_MAX + 1);
   localparam int PRE_W        = (CYC_PER_MS > 1) ? $clog2(CYC_PER_MS) : 1;

   localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RESET_CYCLES - 1);
   localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(ROW_DIV - 1);
   localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(COL_DIV - 1);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CYC_PER_MS - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RESET = 3'd1,
      S_INTEG = 3'd2,
      S_READ  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic [PRE_W-1:0]  pre;
   logic [INT_W-1:0]  ms_cnt;
   logic              in_setup;

   logic [ADDR_W-1:0] row_start_l, row_end_l, col_start_l, col_end_l;
   logic [INT_W-1:0]  int_ms_l;
   logic [ADDR_W:0]   row_inc, col_inc;
   logic [ADDR_W:0]   row_next, col_next;
   logic              row_last, col_last, int_done, cfg_ok, take_start;

   assign cfg_ok     = (row_start <= row_end) && (col_start <= col_end);
   assign take_start = (state == S_IDLE) && frame_start && !frame_abort && cfg_ok;

`ifdef TG_DECIMATE_EN
   logic [1:0] row_step_l, col_step_l;
   assign row_inc = (ADDR_W+1)'(row_step_l) + (ADDR_W+1)'(1);
   assign col_inc = (ADDR_W+1)'(col_step_l) + (ADDR_W+1)'(1);
`else
   logic unused_step;
   assign unused_step = ^{row_step, col_step};
   assign row_inc = (ADDR_W+1)'(1);
   assign col_inc = (ADDR_W+1)'(1);
`endif

   // Configuration snapshot taken on an accepted start; reused by continuous frames.
   always_ff @(posedge clk) begin
      if (take_start) begin
         row_start_l <= row_start;
         row_end_l   <= row_end;
         col_start_l <= col_start;
         col_end_l   <= col_end;
         int_ms_l    <= integration_ms;
`ifdef TG_DECIMATE_EN
         row_step_l  <= row_step;
         col_step_l  <= col_step;
`endif
      end
   end

   // One extra bit so stepping past the top of the address space ends the line instead of wrapping.
   assign row_next = {1'b0, row_addr} + row_inc;
   assign col_next = {1'b0, col_addr} + col_inc;
   assign row_last = row_next > {1'b0, row_end_l};
   assign col_last = col_next > {1'b0, col_end_l};
   assign int_done = (int_ms_l == '0) || ((pre == PRE_LAST) && (ms_cnt == int_ms_l - 1'b1));

   assign state_o = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state             <= S_IDLE;
         cnt               <= '0;
         pre               <= '0;
         ms_cnt            <= '0;
         in_setup          <= 1'b0;
         frame_busy        <= 1'b0;
         frame_complete    <= 1'b0;
         frame_aborted     <= 1'b0;
         cfg_error         <= 1'b0;
         frame_count       <= '0;
         row_addr          <= '0;
         col_addr          <= '0;
         row_clk_en        <= 1'b0;
         col_clk_en        <= 1'b0;
         adc_start_trigger <= 1'b0;
         gate_sel          <= 1'b0;
         reset_pulse       <= 1'b0;
      end else begin
         frame_complete    <= 1'b0;
         frame_aborted     <= 1'b0;
         cfg_error         <= 1'b0;
         row_clk_en        <= 1'b0;
         col_clk_en        <= 1'b0;
         adc_start_trigger <= 1'b0;
         if (state != S_IDLE && frame_abort) begin
            state         <= S_IDLE;
            frame_busy    <= 1'b0;
            gate_sel      <= 1'b0;
            reset_pulse   <= 1'b0;
            frame_aborted <= 1'b1;
         end else begin
            case (state)
               S_IDLE: begin
                  if (frame_start && !frame_abort) begin
                     if (cfg_ok) begin
                        state       <= S_RESET;
                        frame_busy  <= 1'b1;
                        reset_pulse <= 1'b1;
                        cnt         <= '0;
                        row_addr    <= row_start;
                        col_addr    <= col_start;
                     end else begin
                        cfg_error <= 1'b1;
                     end
                  end
               end
               S_RESET: begin
                  if (cnt == RST_LAST) begin
                     state       <= S_INTEG;
                     reset_pulse <= 1'b0;
                     pre         <= '0;
                     ms_cnt      <= '0;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               S_INTEG: begin
                  if (int_done) begin
                     state      <= S_READ;
                     gate_sel   <= 1'b1;
                     row_clk_en <= 1'b1;
                     in_setup   <= 1'b1;
                     cnt        <= '0;
                  end else if (pre == PRE_LAST) begin
                     pre    <= '0;
                     ms_cnt <= ms_cnt + 1'b1;
                  end else begin
                     pre <= pre + 1'b1;
                  end
               end
               S_READ: begin
                  if (in_setup) begin
                     if (cnt == ROW_LAST) begin
                        in_setup   <= 1'b0;
                        cnt        <= '0;
                        col_clk_en <= 1'b1;
                     end else begin
                        cnt <= cnt + 1'b1;
                     end
                  end else begin
                     // Strobes are registered one cycle ahead of the slot cycle they mark.
                     if (cnt == '0) adc_start_trigger <= 1'b1;
                     if (cnt == COL_LAST) begin
                        cnt <= '0;
                        if (!col_last) begin
                           col_addr   <= col_next[ADDR_W-1:0];
                           col_clk_en <= 1'b1;
                        end else if (!row_last) begin
                           row_addr   <= row_next[ADDR_W-1:0];
                           col_addr   <= col_start_l;
                           in_setup   <= 1'b1;
                           row_clk_en <= 1'b1;
                        end else begin
                           state          <= S_DONE;
                           gate_sel       <= 1'b0;
                           frame_busy     <= 1'b0;
                           frame_complete <= 1'b1;
                           frame_count    <= frame_count + 1'b1;
                        end
                     end else begin
                        cnt <= cnt + 1'b1;
                     end
                  end
               end
               S_DONE: begin
                  if (continuous) begin
                     state       <= S_RESET;
                     frame_busy  <= 1'b1;
                     reset_pulse <= 1'b1;
                     cnt         <= '0;
                     row_addr    <= row_start_l;
                     col_addr    <= col_start_l;
                  end else begin
                     state <= S_IDLE;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule
